// File: rtl/whiz_graphics.sv
// whiz_graphics -- DMG-style background graphics peripheral.
//
// Purpose: holds VRAM (8000-9FFF), OAM (FE00-FE9F) and the LCD registers
// (LCDC FF40, SCY/SCX FF42-43, BGP/OBP0/OBP1 FF47-49, WY/WX FF4A-4B) on the
// CPU data bus. Renders a 160x144 2-bit background frame one line per
// drawline strobe and raises renderComplete when all lines are done.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   db_addr        bus address
//   db_data        bus data, tri-state; driven only for mapped reads
//   db_we, db_re   bus write / read strobes
//   drawline       line-advance enable, sampled at posedge clk
//   renderComplete high after line 143 is written, held until reset
//   lcd            [0:143][0:159] 2-bit shades (0 = white .. 3 = black)
//
// Optional feature: define WHIZ_WINDOW_EN to enable the window layer.
// Without it WY/WX are stored and readable only.
//
// Render FSM states:
//   state  | meaning
//   S_IDLE | one cycle after reset before drawing starts
//   S_DRAW | each drawline renders line ly into lcd and advances ly
//   S_DONE | all 144 lines written, renderComplete held
module whiz_graphics #(
  parameter int DEBUG_OUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] db_addr,
  inout  wire  [7:0]  db_data,
  input  logic        db_we,
  input  logic        db_re,
  input  logic        drawline,
  output logic        renderComplete,
  output logic [1:0]  lcd [0:143][0:159]
);

  localparam logic [15:0] VRAM_TILES_ADDR       = 16'h8000;
  localparam int          VRAM_TILES_SIZE       = 6144;
  localparam logic [15:0] VRAM_BACKGROUND1_ADDR = 16'h9800;
  localparam int          VRAM_BACKGROUND1_SIZE = 1024;
  localparam logic [15:0] VRAM_BACKGROUND2_ADDR = 16'h9C00;
  localparam int          VRAM_BACKGROUND2_SIZE = 1024;
  localparam logic [15:0] OAM_LOC               = 16'hFE00;
  localparam int          OAM_SIZE              = 160;
  localparam logic [15:0] LCDC_ADDR             = 16'hFF40;
  localparam int          LCDC_SIZE             = 1;
  localparam logic [15:0] LCD_POS_ADDR          = 16'hFF42;
  localparam int          LCD_POS_SIZE          = 2;
  localparam logic [15:0] LCD_PALLETE_ADDR      = 16'hFF47;
  localparam int          LCD_PALLETE_SIZE      = 3;
  localparam logic [15:0] LCD_WIN_ADDR          = 16'hFF4A;
  localparam int          LCD_WIN_SIZE          = 2;

  localparam int          VRAM_SIZE = VRAM_TILES_SIZE + VRAM_BACKGROUND1_SIZE + VRAM_BACKGROUND2_SIZE;
  localparam logic [12:0] MAP1_OFF  = 13'(VRAM_BACKGROUND1_ADDR - VRAM_TILES_ADDR);
  localparam logic [12:0] MAP2_OFF  = 13'(VRAM_BACKGROUND2_ADDR - VRAM_TILES_ADDR);
  localparam logic [7:0]  LAST_LINE = 8'd143;

  typedef struct packed {
    logic [7:0] y_position;
    logic [7:0] x_position;
    logic [7:0] tile;
    logic [7:0] flags;
  } oam_attr_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  // Unsigned wrap of (a - base) turns a two-sided range check into one compare.
  function automatic logic in_range(input logic [15:0] a, input logic [15:0] base, input int size);
    return (a - base) < 16'(size);
  endfunction

  logic [7:0] vram_q [0:VRAM_SIZE-1];
  oam_attr_t  oam_table [0:39];

  logic [7:0] lcdc_q, lcdc_d, scy_q, scy_d, scx_q, scx_d;
  logic [7:0] bgp_q, bgp_d, obp0_q, obp0_d, obp1_q, obp1_d, wy_q, wy_d, wx_q, wx_d;
  state_t     state_q, state_d;
  logic [7:0] ly_q, ly_d;
  logic       render_complete_q, render_complete_d;
  logic       line_we;
  logic [1:0] lcd_q [0:143][0:159];
  logic [1:0] line_pix [0:159];

  logic       hit_vram, hit_oam, hit_reg, rd_hit;
  logic [7:0] rd_data;
  oam_attr_t  oam_rd;

  logic unused_debug;
  assign unused_debug = (DEBUG_OUT != 0);

  // ---------------- bus decode / read ----------------
  assign hit_vram = in_range(db_addr, VRAM_TILES_ADDR, VRAM_SIZE);
  assign hit_oam  = in_range(db_addr, OAM_LOC, OAM_SIZE);
  assign hit_reg  = in_range(db_addr, LCDC_ADDR, LCDC_SIZE)
                 || in_range(db_addr, LCD_POS_ADDR, LCD_POS_SIZE)
                 || in_range(db_addr, LCD_PALLETE_ADDR, LCD_PALLETE_SIZE)
                 || in_range(db_addr, LCD_WIN_ADDR, LCD_WIN_SIZE);
  assign oam_rd   = oam_table[db_addr[7:2]];

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'h00;
    if (hit_vram) begin
      rd_hit  = 1'b1;
      rd_data = vram_q[db_addr[12:0]];
    end else if (hit_oam) begin
      rd_hit = 1'b1;
      case (db_addr[1:0])
        2'd0:    rd_data = oam_rd.y_position;
        2'd1:    rd_data = oam_rd.x_position;
        2'd2:    rd_data = oam_rd.tile;
        default: rd_data = oam_rd.flags;
      endcase
    end else if (hit_reg) begin
      rd_hit = 1'b1;
      case (db_addr)
        LCDC_ADDR:                rd_data = lcdc_q;
        LCD_POS_ADDR:             rd_data = scy_q;
        LCD_POS_ADDR + 16'd1:     rd_data = scx_q;
        LCD_PALLETE_ADDR:         rd_data = bgp_q;
        LCD_PALLETE_ADDR + 16'd1: rd_data = obp0_q;
        LCD_PALLETE_ADDR + 16'd2: rd_data = obp1_q;
        LCD_WIN_ADDR:             rd_data = wy_q;
        default:                  rd_data = wx_q;
      endcase
    end
  end

  assign db_data = (db_re && rd_hit) ? rd_data : 8'hzz;

  // ---------------- bus writes ----------------
  always_ff @(posedge clk) begin
    if (db_we && hit_vram) vram_q[db_addr[12:0]] <= db_data;
    if (db_we && hit_oam) begin
      case (db_addr[1:0])
        2'd0:    oam_table[db_addr[7:2]].y_position <= db_data;
        2'd1:    oam_table[db_addr[7:2]].x_position <= db_data;
        2'd2:    oam_table[db_addr[7:2]].tile       <= db_data;
        default: oam_table[db_addr[7:2]].flags      <= db_data;
      endcase
    end
  end

  always_comb begin
    lcdc_d = lcdc_q; scy_d = scy_q; scx_d = scx_q;
    bgp_d = bgp_q; obp0_d = obp0_q; obp1_d = obp1_q;
    wy_d = wy_q; wx_d = wx_q;
    if (db_we) begin
      case (db_addr)
        LCDC_ADDR:                lcdc_d = db_data;
        LCD_POS_ADDR:             scy_d  = db_data;
        LCD_POS_ADDR + 16'd1:     scx_d  = db_data;
        LCD_PALLETE_ADDR:         bgp_d  = db_data;
        LCD_PALLETE_ADDR + 16'd1: obp0_d = db_data;
        LCD_PALLETE_ADDR + 16'd2: obp1_d = db_data;
        LCD_WIN_ADDR:             wy_d   = db_data;
        LCD_WIN_ADDR + 16'd1:     wx_d   = db_data;
        default: ;
      endcase
    end
  end

  // ---------------- render FSM ----------------
  always_comb begin
    state_d           = state_q;
    ly_d              = ly_q;
    render_complete_d = render_complete_q;
    line_we           = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_DRAW;
      S_DRAW: begin
        if (drawline) begin
          line_we = 1'b1;
          if (ly_q == LAST_LINE) begin
            state_d           = S_DONE;
            render_complete_d = 1'b1;
          end else begin
            ly_d = ly_q + 8'd1;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; ly_q <= 8'd0; render_complete_q <= 1'b0;
      lcdc_q <= 8'h91; scy_q <= 8'h00; scx_q <= 8'h00;
      bgp_q <= 8'hFC; obp0_q <= 8'hFF; obp1_q <= 8'hFF;
      wy_q <= 8'h00; wx_q <= 8'h00;
    end else begin
      state_q <= state_d; ly_q <= ly_d; render_complete_q <= render_complete_d;
      lcdc_q <= lcdc_d; scy_q <= scy_d; scx_q <= scx_d;
      bgp_q <= bgp_d; obp0_q <= obp0_d; obp1_q <= obp1_d;
      wy_q <= wy_d; wx_q <= wx_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int y = 0; y < 144; y++)
        for (int x = 0; x < 160; x++)
          lcd_q[y][x] <= 2'b00;
    end else if (line_we) begin
      for (int x = 0; x < 160; x++)
        lcd_q[ly_q][x] <= line_pix[x];
    end
  end

  assign lcd            = lcd_q;
  assign renderComplete = render_complete_q;

  // ---------------- per-pixel fetch for line ly ----------------
  for (genvar gx = 0; gx < 160; gx++) begin : g_px
    logic [7:0]  px_x, fx, fy, tile_idx, lo_b, hi_b;
    logic [12:0] map_off, tile_off;
    logic [2:0]  bit_sel;
    logic [1:0]  color;
    logic        use_win, msel;

    assign px_x = 8'(gx);
`ifdef WHIZ_WINDOW_EN
    assign use_win = lcdc_q[5] && (ly_q >= wy_q) && ((px_x + 8'd7) >= wx_q);
`else
    assign use_win = 1'b0;
`endif
    assign fy   = use_win ? (ly_q - wy_q) : (ly_q + scy_q);
    assign fx   = use_win ? (px_x + 8'd7 - wx_q) : (px_x + scx_q);
    assign msel = use_win ? lcdc_q[6] : lcdc_q[3];

    assign map_off  = (msel ? MAP2_OFF : MAP1_OFF) | {3'b000, fy[7:3], fx[7:3]};
    assign tile_idx = vram_q[map_off];
    // Signed mode (LCDC.4=0) places idx 0..127 at 9000 and 128..255 at 8800,
    // which is just bit 12 set for the lower half of the index range.
    assign tile_off = {~lcdc_q[4] & ~tile_idx[7], tile_idx, fy[2:0], 1'b0};
    assign lo_b     = vram_q[tile_off];
    assign hi_b     = vram_q[tile_off | 13'd1];
    assign bit_sel  = ~fx[2:0];
    assign color    = {hi_b[bit_sel], lo_b[bit_sel]};
    assign line_pix[gx] = (lcdc_q[7] && lcdc_q[0]) ? bgp_q[{color, 1'b0} +: 2] : 2'b00;
  end

endmodule

// File: tb/tb_whiz_graphics.sv
module tb_whiz_graphics;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] db_addr;
  wire  [7:0]  db_data;
  logic [7:0]  tb_data;
  logic        tb_drive, db_we, db_re, drawline;
  logic        renderComplete;
  logic [1:0]  lcd [0:143][0:159];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  assign db_data = tb_drive ? tb_data : 8'hzz;
  always #5 clk = ~clk;

  whiz_graphics dut (
    .clk(clk), .reset(reset), .db_addr(db_addr), .db_data(db_data),
    .db_we(db_we), .db_re(db_re), .drawline(drawline),
    .renderComplete(renderComplete), .lcd(lcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    db_addr = a; tb_data = d; tb_drive = 1'b1; db_we = 1'b1;
    @(negedge clk);
    db_we = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    db_addr = a; db_re = 1'b1;
    #2 d = db_data;
    db_re = 1'b0;
  endtask

  task automatic sb_write(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    bus_write(a, d);
    e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    logic [7:0] r;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus_read(e.addr, r);
      check($sformatf("readback %h", e.addr), r, e.data);
    end
  endtask

  task automatic fill(input logic [15:0] base, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) bus_write(base + 16'(i), v);
  endtask

  function automatic int count_ne(input logic [1:0] v);
    int n = 0;
    for (int y = 0; y < 144; y++)
      for (int x = 0; x < 160; x++)
        if (lcd[y][x] !== v) n++;
    return n;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; drawline = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_render(input string tag, input int min_cyc);
    int cyc = 0;
    drawline = 1'b1;
    while (!renderComplete && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    drawline = 1'b0;
    check({tag, " complete"}, renderComplete, 1);
    check({tag, " cycle budget"}, (cyc >= min_cyc && cyc <= 150), 1);
  endtask

  logic [15:0] reg_addr [8];
  logic [7:0]  reg_rst  [8];
  logic [7:0]  ob [4];
  logic [7:0]  r;

  initial begin
    reg_addr = '{16'hFF40, 16'hFF42, 16'hFF43, 16'hFF47, 16'hFF48, 16'hFF49, 16'hFF4A, 16'hFF4B};
    reg_rst  = '{8'h91, 8'h00, 8'h00, 8'hFC, 8'hFF, 8'hFF, 8'h00, 8'h00};
    reset = 1'b1; db_addr = '0; tb_data = '0; tb_drive = 1'b0;
    db_we = 1'b0; db_re = 1'b0; drawline = 1'b0;
    repeat (3) @(negedge clk);
    check("reset renderComplete", renderComplete, 0);
    check("reset lcd clear", count_ne(2'd0), 0);
    reset = 1'b0;

    // register reset values
    for (int i = 0; i < 8; i++) begin
      bus_read(reg_addr[i], r);
      check($sformatf("reset reg %h", reg_addr[i]), r, reg_rst[i]);
    end

    // OAM entry 0 through the bus and through the attribute table
    for (int i = 0; i < 4; i++) begin
      ob[i] = 8'($urandom_range(0, 255));
      sb_write(16'hFE00 + 16'(i), ob[i]);
    end
    sb_write(16'hFE9F, 8'h5A);
    sb_drain();
    check("oam y_position", dut.oam_table[0].y_position, ob[0]);
    check("oam x_position", dut.oam_table[0].x_position, ob[1]);
    check("oam tile",       dut.oam_table[0].tile,       ob[2]);
    check("oam flags",      dut.oam_table[0].flags,      ob[3]);

    // full VRAM and all registers
    for (int a = 16'h8000; a < 16'hA000; a++)
      sb_write(16'(a), 8'($urandom_range(0, 255)));
    sb_drain();
    for (int i = 0; i < 8; i++) sb_write(reg_addr[i], 8'($urandom_range(0, 255)));
    sb_drain();

    // unmapped neighbours must not alias into mapped storage
    sb_write(16'h8000, 8'hA5);
    sb_write(16'hFE00, 8'h3C);
    bus_write(16'hA000, 8'h11);
    bus_write(16'hFEA0, 8'h22);
    bus_write(16'hFF41, 8'h33);
    sb_drain();

    // render 1: tile0 solid FF, map all 0 -> every pixel shade 3
    fill(16'h9800, 1024, 8'h00);
    fill(16'h8000, 16, 8'hFF);
    pulse_reset();
    bus_write(16'hFF47, 8'hE4);
    run_render("solid", 144);
    check("solid all shade 3", count_ne(2'd3), 0);
    check("solid corner", lcd[143][159], 3);

    // render 2: SCX=8, map[1]=tile1 (all 00); pause drawline mid-frame
    fill(16'h8010, 16, 8'h00);
    bus_write(16'h9801, 8'h01);
    pulse_reset();
    check("reset clears lcd", count_ne(2'd0), 0);
    bus_write(16'hFF47, 8'hE4);
    bus_write(16'hFF43, 8'h08);
    drawline = 1'b1;
    repeat (5) @(posedge clk);
    #1 drawline = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pause line4 drawn", lcd[4][8], 3);
    check("pause line5 held", lcd[5][8], 0);
    check("pause not complete", renderComplete, 0);
    run_render("scx", 139);
    for (int x = 0; x < 16; x++)
      check($sformatf("scx lcd[0][%0d]", x), lcd[0][x], (x < 8) ? 0 : 3);
    check("scx lcd[7][0]", lcd[7][0], 0);
    check("scx lcd[8][0]", lcd[8][0], 3);
    check("scx lcd[0][159]", lcd[0][159], 3);

    // render 3: signed tile addressing (LCDC.4=0)
    for (int i = 0; i < 16; i++) bus_write(16'h9000 + 16'(i), (i % 2 == 0) ? 8'h0F : 8'hF0);
    fill(16'h8800, 16, 8'hFF);
    bus_write(16'h9801, 8'h80);
    pulse_reset();
    bus_write(16'hFF40, 8'h81);
    bus_write(16'hFF47, 8'hE4);
    run_render("signed", 144);
    check("signed lcd[0][0]", lcd[0][0], 2);
    check("signed lcd[0][3]", lcd[0][3], 2);
    check("signed lcd[0][4]", lcd[0][4], 1);
    check("signed lcd[0][8]", lcd[0][8], 3);
    check("signed lcd[0][16]", lcd[0][16], 2);
    check("signed lcd[100][20]", lcd[100][20], 1);

    // render 4: display disabled -> shade 0 everywhere
    pulse_reset();
    bus_write(16'hFF40, 8'h11);
    run_render("lcd off", 144);
    check("lcd off all 0", count_ne(2'd0), 0);

    // reset mid-render, then full re-render (tiles 0 and 0x80 are solid FF)
    pulse_reset();
    drawline = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("mid line69 drawn", lcd[69][0], 3);
    check("mid line70 pending", lcd[70][0], 0);
    check("mid not complete", renderComplete, 0);
    reset = 1'b1;
    #1;
    check("mid reset renderComplete", renderComplete, 0);
    check("mid reset lcd clear", count_ne(2'd0), 0);
    drawline = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    run_render("rerender", 144);
    check("rerender all 3", count_ne(2'd3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
